// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scanner with frame snapshots, dead time,
// per-digit decimal point and blink.
module seg_scan_mux #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 65536,
    parameter int BLANK_CYCLES = 256,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [5*DIGITS-1:0]   digit_codes,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [DIGITS-1:0]     seg_selector,
    output logic [7:0]            segments,
    output logic                  frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic                  phase_q, phase_d;
    logic [5*DIGITS-1:0]   codes_q, codes_d;
    logic [DIGITS-1:0]     dp_q, dp_d;
    logic [DIGITS-1:0]     blink_q, blink_d;
    logic [DIGITS-1:0]     sel_q, sel_d;
    logic [7:0]            seg_q, seg_d;
    logic                  tick_q, tick_d;

    logic                  slot_end;
    logic                  frame_end;
    logic                  snap;
    logic                  dead;
    logic                  dark;
    logic [5*DIGITS-1:0]   codes_eff;
    logic [DIGITS-1:0]     dp_eff;
    logic [DIGITS-1:0]     blink_eff;
    logic [4:0]            code_cur;

    function automatic logic [7:0] glyph(input logic [4:0] c);
        case (c)
            5'd0:    glyph = 8'h03;
            5'd1:    glyph = 8'h9F;
            5'd2:    glyph = 8'h25;
            5'd3:    glyph = 8'h0D;
            5'd4:    glyph = 8'h99;
            5'd5:    glyph = 8'h49;
            5'd6:    glyph = 8'h41;
            5'd7:    glyph = 8'h1F;
            5'd8:    glyph = 8'h01;
            5'd9:    glyph = 8'h09;
            5'd10:   glyph = 8'h11;
            5'd11:   glyph = 8'hC1;
            5'd12:   glyph = 8'h63;
            5'd13:   glyph = 8'h31;
            5'd14:   glyph = 8'h49;
            5'd16:   glyph = 8'hFD;
            default: glyph = 8'hFF;
        endcase
    endfunction

    generate
        if (BLANK_CYCLES == 0) begin : g_no_dead
            assign dead = 1'b0;
        end else begin : g_dead
            assign dead = ({1'b0, cnt_q} < (CW + 1)'(BLANK_CYCLES));
        end
    endgenerate

    always_comb begin
        slot_end  = (cnt_q == CW'(SCAN_DIV - 1));
        frame_end = slot_end && (idx_q == IW'(DIGITS - 1));
        snap      = (cnt_q == '0) && (idx_q == '0);

        // The loading cycle displays the freshly captured inputs so the
        // whole frame comes from one coherent snapshot.
        codes_eff = snap ? digit_codes : codes_q;
        dp_eff    = snap ? dp_mask : dp_q;
        blink_eff = snap ? blink_mask : blink_q;
        codes_d   = codes_eff;
        dp_d      = dp_eff;
        blink_d   = blink_eff;

        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (frame_end) begin
            if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end

        code_cur = codes_eff[5*idx_q +: 5];
        dark     = !enable || dead || (phase_q && blink_eff[idx_q]);

        sel_d = '1;
        seg_d = 8'hFF;
        if (!dark) begin
            sel_d = ~(DIGITS'(1) << idx_q);
            seg_d = glyph(code_cur);
            if (dp_eff[idx_q]) begin
                seg_d[0] = 1'b0;
            end
        end
        tick_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            codes_q <= {DIGITS{5'd15}};
            dp_q    <= '0;
            blink_q <= '0;
            sel_q   <= '1;
            seg_q   <= 8'hFF;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            codes_q <= codes_d;
            dp_q    <= dp_d;
            blink_q <= blink_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            tick_q  <= tick_d;
        end
    end

    assign seg_selector = sel_q;
    assign segments     = seg_q;
    assign frame_tick   = tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with small scan parameters.
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [19:0] digit_codes;
    logic [3:0]  dp_mask;
    logic [3:0]  blink_mask;
    logic [3:0]  seg_selector;
    logic [7:0]  segments;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         n;
        logic [3:0] sel;
        logic [7:0] seg;
        logic       tick;
    } vec_t;

    vec_t       tbl[17];
    logic [3:0] sel_log[192];
    logic [7:0] seg_log[192];
    logic       tick_log[192];

    seg_scan_mux #(
        .DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .digit_codes(digit_codes), .dp_mask(dp_mask),
        .blink_mask(blink_mask), .seg_selector(seg_selector),
        .segments(segments), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_out(string name, logic [3:0] s, logic [7:0] g,
                           logic t);
        chk({name, " sel"}, 32'(seg_selector), 32'(s));
        chk({name, " seg"}, 32'(segments), 32'(g));
        chk({name, " tick"}, 32'(frame_tick), 32'(t));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
    endtask

    // Independent reference for run A, in terms of the state number n.
    function automatic logic [11:0] model_a(int n);
        int f, d, c;
        logic ph;
        logic [7:0] g;
        f  = n / 32;
        d  = (n / 8) % 4;
        c  = n % 8;
        ph = ((f / 2) % 2) == 1;
        if (c < 2 || (ph && d == 0)) return {4'hF, 8'hFF};
        case (d)
            0:       g = (f == 0) ? 8'h03 : 8'h25;
            1:       g = 8'hC0;
            2:       g = 8'h63;
            default: g = 8'h31;
        endcase
        return {~(4'b0001 << d), g};
    endfunction

    initial begin
        tbl[0]  = '{0,   4'hF, 8'hFF, 1'b0};
        tbl[1]  = '{1,   4'hF, 8'hFF, 1'b0};
        tbl[2]  = '{2,   4'hE, 8'h03, 1'b0};
        tbl[3]  = '{7,   4'hE, 8'h03, 1'b0};
        tbl[4]  = '{8,   4'hF, 8'hFF, 1'b0};
        tbl[5]  = '{10,  4'hD, 8'hC0, 1'b0};
        tbl[6]  = '{18,  4'hB, 8'h63, 1'b0};
        tbl[7]  = '{26,  4'h7, 8'h31, 1'b0};
        tbl[8]  = '{31,  4'h7, 8'h31, 1'b1};
        tbl[9]  = '{32,  4'hF, 8'hFF, 1'b0};
        tbl[10] = '{34,  4'hE, 8'h25, 1'b0};
        tbl[11] = '{63,  4'h7, 8'h31, 1'b1};
        tbl[12] = '{66,  4'hF, 8'hFF, 1'b0};
        tbl[13] = '{74,  4'hD, 8'hC0, 1'b0};
        tbl[14] = '{127, 4'h7, 8'h31, 1'b1};
        tbl[15] = '{130, 4'hE, 8'h25, 1'b0};
        tbl[16] = '{160, 4'hF, 8'hFF, 1'b0};

        enable      = 1'b1;
        digit_codes = {5'd13, 5'd12, 5'd11, 5'd0};
        dp_mask     = 4'b0010;
        blink_mask  = 4'b0001;
        do_reset();
        chk_out("reset", 4'hF, 8'hFF, 1'b0);

        // Run A: scan, mid-frame code change, dp and blink.
        rst = 1'b0;
        for (int n = 0; n < 192; n++) begin
            if (n == 10) digit_codes[4:0] = 5'd2;
            step();
            sel_log[n]  = seg_selector;
            seg_log[n]  = segments;
            tick_log[n] = frame_tick;
        end
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("tblA n=%0d sel", tbl[i].n),
                32'(sel_log[tbl[i].n]), 32'(tbl[i].sel));
            chk($sformatf("tblA n=%0d seg", tbl[i].n),
                32'(seg_log[tbl[i].n]), 32'(tbl[i].seg));
            chk($sformatf("tblA n=%0d tick", tbl[i].n),
                32'(tick_log[tbl[i].n]), 32'(tbl[i].tick));
        end
        for (int n = 0; n < 192; n++) begin
            chk($sformatf("modelA n=%0d", n),
                {19'd0, tick_log[n], sel_log[n], seg_log[n]},
                {19'd0, (n % 32) == 31, model_a(n)});
        end

        // Run B: enable dropped for states 3..7 of digit0.
        digit_codes = {5'd13, 5'd12, 5'd11, 5'd0};
        dp_mask     = 4'b0000;
        blink_mask  = 4'b0000;
        do_reset();
        rst = 1'b0;
        for (int n = 0; n < 32; n++) begin
            enable = !(n >= 3 && n <= 7);
            step();
            if (n == 2)  chk_out("B lit n2", 4'hE, 8'h03, 1'b0);
            if (n == 3)  chk_out("B off n3", 4'hF, 8'hFF, 1'b0);
            if (n == 7)  chk_out("B off n7", 4'hF, 8'hFF, 1'b0);
            if (n == 10) chk_out("B resume n10", 4'hD, 8'hC1, 1'b0);
            if (n == 31) chk_out("B tick n31", 4'h7, 8'h31, 1'b1);
        end

        // Run C: dash / unused codes and reset mid-frame.
        enable      = 1'b1;
        digit_codes = {5'd0, 5'd0, 5'd20, 5'd16};
        do_reset();
        rst = 1'b0;
        for (int n = 0; n < 13; n++) begin
            step();
            if (n == 2)  chk_out("C dash n2", 4'hE, 8'hFD, 1'b0);
            if (n == 10) chk_out("C code20 n10", 4'hD, 8'hFF, 1'b0);
        end
        rst = 1'b1;
        step();
        chk_out("C rst edge1", 4'hF, 8'hFF, 1'b0);
        step();
        chk_out("C rst edge2", 4'hF, 8'hFF, 1'b0);
        rst = 1'b0;
        for (int n = 0; n < 11; n++) begin
            step();
            if (n == 0)  chk_out("C restart n0", 4'hF, 8'hFF, 1'b0);
            if (n == 2)  chk_out("C restart n2", 4'hE, 8'hFD, 1'b0);
            if (n == 10) chk_out("C restart n10", 4'hD, 8'hFF, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
